// File: rtl/sar_search.sv
// sar_search: successive-approximation controller for an external magnitude
// comparator. It drives the trial (B) operand one bit per cycle, MSB first,
// reads the gt/lt/eq relation flags and returns the recovered A as result.
// Optional build macro SAR_ONEHOT_CHECK_EN: abort a search with err=1 when the
// relation flags are not exactly one-hot. When the macro is undefined, err is tied to 0.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_TRIAL = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] next_bit;
  logic             flags_bad;

  // Working value after this compare, the next probe bit, and the flag sanity check
  always_comb begin
    work      = trial;
    next_bit  = '0;
    flags_bad = 1'b0;
    if (cmp_lt) begin
      work = trial & ~(WIDTH'(1) << idx);
    end
    if (idx != '0) begin
      next_bit = WIDTH'(1) << (idx - IW'(1));
    end
    flags_bad = !(({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                  ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                  ({cmp_gt, cmp_lt, cmp_eq} == 3'b001));
  end

`ifndef SAR_ONEHOT_CHECK_EN
  // Without the check, gt is the implied fall-through case and err never asserts
  logic unused_flags;
  assign unused_flags = cmp_gt ^ flags_bad;
  assign err = 1'b0;
`endif

  // Search sequencer: one compare per cycle, eq > lt > gt priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      exact  <= 1'b0;
      idx    <= IW'(WIDTH - 1);
`ifdef SAR_ONEHOT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            trial <= MSB_TRIAL;
            idx   <= IW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= SEARCH;
          end
        end
        SEARCH: begin
`ifdef SAR_ONEHOT_CHECK_EN
          if (flags_bad) begin
            result <= '0;
            exact  <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else
`endif
          if (cmp_eq) begin
            result <= trial;
            exact  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
          end else if (idx == '0) begin
            result <= work;
            exact  <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
          end else begin
            trial <= work | next_bit;
            idx   <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a comparator model answers each trial from a hidden A,
// a reference search model predicts trials and outcomes into queues, and a
// negedge monitor checks DUT activity against those queues.
module tb_sar_search;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] result;
    logic         exact;
    logic         err;
    logic [31:0]  lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_gt, cmp_lt, cmp_eq;
  logic [W-1:0] trial, result;
  logic         busy, done, exact, err;

  int   a_val = 0;
  int   corrupt_k = 0;
  int   cmp_cnt = 0;
  logic corrupt;

  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];
  int   exp_trials[$];

  logic [W-1:0] held_res = '0;
  logic         held_exact = 1'b0;
  logic         held_err = 1'b0;
  bit           b2b = 1'b0;
  int           last_done = -1;
  int           cyc = 0;
  int           busy_cnt = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .exact(exact), .err(err)
  );

  always #5 clk = ~clk;

  // Index of the compare currently being presented (1 = first trial)
  always @(posedge clk) cmp_cnt <= busy ? cmp_cnt + 1 : 1;

  // Comparator model; optionally reports gt and lt together on one compare
  assign corrupt = (corrupt_k != 0) && busy && (cmp_cnt == corrupt_k);
  assign cmp_gt  = corrupt | (a_val > int'(trial));
  assign cmp_lt  = corrupt | (a_val < int'(trial));
  assign cmp_eq  = ~corrupt & (a_val == int'(trial));

  function automatic void check(input string name, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
  endfunction

  // Reference: bitwise binary search for A, bits known so far kept in 'known'
  function automatic void model(input int a, input int ck);
    int   known = 0;
    exp_t e;
    for (int b = int'(W) - 1; b >= 0; b--) begin
      int t;
      int k;
      bit is_eq;
      bit is_lt;
      t = known | (1 << b);
      k = int'(W) - b;
      exp_trials.push_back(t);
      is_eq = (a == t);
      is_lt = (a < t);
      if (k == ck) begin
`ifdef SAR_ONEHOT_CHECK_EN
        e.result = '0; e.exact = 1'b0; e.err = 1'b1; e.lat = 32'(k);
        exp_q.push_back(e);
        return;
`else
        is_eq = 1'b0;
        is_lt = 1'b1;
`endif
      end
      if (is_eq) begin
        e.result = W'(t); e.exact = 1'b1; e.err = 1'b0; e.lat = 32'(k);
        exp_q.push_back(e);
        return;
      end
      if (!is_lt) known = t;
    end
    e.result = W'(known); e.exact = 1'b0; e.err = 1'b0; e.lat = 32'(W);
    exp_q.push_back(e);
  endfunction

  // Monitor: trials while busy, outcome on done, held outputs otherwise
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (exp_trials.size() == 0) check("trial_extra", int'(trial), -1);
        else check("trial", int'(trial), exp_trials.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", int'(result), int'(e.result));
          check("exact", int'(exact), int'(e.exact));
          check("err", int'(err), int'(e.err));
          check("latency", busy_cnt, int'(e.lat));
          check("busy_at_done", int'(busy), 0);
          held_res = e.result; held_exact = e.exact; held_err = e.err;
          if (b2b && last_done >= 0) check("b2b_interval", cyc - last_done, 5);
          last_done = cyc;
        end
        busy_cnt = 0;
      end else begin
        check("result_held", int'(result), int'(held_res));
        check("exact_held", int'(exact), int'(held_exact));
        check("err_held", int'(err), int'(held_err));
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trial"}, int'(trial), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_exact"}, int'(exact), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  // One search for A=a; ck forces gt+lt on that compare; poke pulses start while busy
  task automatic run(input int a, input int ck, input bit poke);
    int n;
    a_val = a;
    corrupt_k = ck;
    model(a, ck);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      start = poke && (n == 0);
      tick();
      n++;
    end
    start = 1'b0;
    if (busy) check("search_timeout", 1, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run(5, 0, 1'b0);
    run(8, 0, 1'b0);
    run(0, 0, 1'b0);
    run(15, 0, 1'b1);
    run(5, 2, 1'b0);
    tick();

    // Reset during the second SEARCH cycle: no done, everything cleared
    a_val = 5;
    corrupt_k = 0;
    model(5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_trials.delete();
    held_res = '0; held_exact = 1'b0; held_err = 1'b0;
    check_zero("midreset");
    tick();
    tick();

    // start held high: back-to-back searches for A=3
    a_val = 3;
    b2b = 1'b1;
    last_done = -1;
    repeat (4) model(3, 0);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 1 && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("b2b_timeout", 1, 0);
    b2b = 1'b0;
    tick();

    // Randomized searches with occasional flag corruption and busy pokes
    for (int i = 0; i < 40; i++) begin
      int a;
      int ck;
      a = int'($urandom_range(0, (1 << W) - 1));
      ck = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      run(a, ck, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("outcomes_left", exp_q.size(), 0);
    check("trials_left", exp_trials.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
